// File: rtl/ddr4_request_queue.sv
// rtl/ddr4_request_queue.sv - in-order request FIFO issuing one request at a time to the DDR4 controller
// Each request is held until completion or timeout, then answered over the response channel.
module ddr4_request_queue #(
  parameter int PADDR_BITS = 19,
  parameter int DATA_BITS  = 64,
  parameter int DEPTH      = 4,
  parameter int TIMEOUT    = 4096
) (
  input  logic                       clk_in,
  input  logic                       rst_N_in,
  input  logic                       req_valid_in,
  output logic                       req_ready_out,
  input  logic                       req_write_in,
  input  logic [PADDR_BITS-2:0]      req_addr_in,
  input  logic [DATA_BITS-1:0]       req_wdata_in,
  output logic                       ctrl_valid_out,
  input  logic                       ctrl_ready_in,
  output logic [PADDR_BITS-1:0]      ctrl_addr_out,
  output logic [DATA_BITS-1:0]       ctrl_wdata_out,
  output logic                       ctrl_wen_out,
  input  logic                       ctrl_done_in,
  input  logic [DATA_BITS-1:0]       ctrl_rdata_in,
  output logic                       rsp_valid_out,
  input  logic                       rsp_ready_in,
  output logic                       rsp_write_out,
  output logic                       rsp_error_out,
  output logic [DATA_BITS-1:0]       rsp_rdata_out,
  output logic [$clog2(DEPTH):0]     count_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic                  mem_write [DEPTH];
  logic [PADDR_BITS-2:0] mem_addr  [DEPTH];
  logic [DATA_BITS-1:0]  mem_wdata [DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [1:0]    state;
  logic [TW-1:0] timer;
  logic          full;
  logic          push;
  logic          pop;

  assign full  = (count == CW'(DEPTH));
  assign pop   = (state == S_IDLE) && (count != '0);
  // A pop in the same cycle frees a slot, so a full queue can still take one entry.
  assign req_ready_out  = !full || pop;
  assign push           = req_valid_in && req_ready_out;
  assign count_out      = count;
  assign ctrl_valid_out = (state == S_ISSUE);
  assign rsp_valid_out  = (state == S_RESP);

  always_ff @(posedge clk_in) begin
    if (push) begin
      mem_write[tail] <= req_write_in;
      mem_addr[tail]  <= req_addr_in;
      mem_wdata[tail] <= req_wdata_in;
    end
  end

  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      state          <= S_IDLE;
      timer          <= '0;
      ctrl_addr_out  <= '0;
      ctrl_wdata_out <= '0;
      ctrl_wen_out   <= 1'b0;
      rsp_write_out  <= 1'b0;
      rsp_error_out  <= 1'b0;
      rsp_rdata_out  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            ctrl_addr_out  <= {mem_write[head], mem_addr[head]};
            ctrl_wdata_out <= mem_wdata[head];
            ctrl_wen_out   <= mem_write[head];
            state          <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (ctrl_ready_in) begin
            timer <= '0;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (ctrl_done_in) begin
            rsp_write_out <= ctrl_addr_out[PADDR_BITS-1];
            rsp_error_out <= 1'b0;
            rsp_rdata_out <= ctrl_addr_out[PADDR_BITS-1] ? '0 : ctrl_rdata_in;
            state         <= S_RESP;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            rsp_write_out <= ctrl_addr_out[PADDR_BITS-1];
            rsp_error_out <= 1'b1;
            rsp_rdata_out <= '0;
            state         <= S_RESP;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: begin
          if (rsp_ready_in) begin
            ctrl_wen_out  <= 1'b0;
            rsp_write_out <= 1'b0;
            rsp_error_out <= 1'b0;
            rsp_rdata_out <= '0;
            state         <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr4_request_queue.sv
// tb/tb_ddr4_request_queue.sv - scoreboard bench for ddr4_request_queue
// A behavioural controller/requester model runs alongside the scenario tasks.
module tb_ddr4_request_queue;

  localparam int PADDR_BITS = 19;
  localparam int DATA_BITS  = 64;
  localparam int DEPTH      = 4;
  localparam int TIMEOUT    = 4096;

  logic                  clk_in = 1'b0;
  logic                  rst_N_in;
  logic                  req_valid_in;
  logic                  req_ready_out;
  logic                  req_write_in;
  logic [PADDR_BITS-2:0] req_addr_in;
  logic [DATA_BITS-1:0]  req_wdata_in;
  logic                  ctrl_valid_out;
  logic                  ctrl_ready_in;
  logic [PADDR_BITS-1:0] ctrl_addr_out;
  logic [DATA_BITS-1:0]  ctrl_wdata_out;
  logic                  ctrl_wen_out;
  logic                  ctrl_done_in;
  logic [DATA_BITS-1:0]  ctrl_rdata_in;
  logic                  rsp_valid_out;
  logic                  rsp_ready_in;
  logic                  rsp_write_out;
  logic                  rsp_error_out;
  logic [DATA_BITS-1:0]  rsp_rdata_out;
  logic [2:0]            count_out;

  typedef struct packed {
    logic        w;
    logic        e;
    logic [63:0] d;
  } rsp_t;

  rsp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic        ctrl_accept = 1'b1;
  logic        rsp_accept = 1'b1;
  int          done_delay = 0;
  logic        hang_en = 1'b0;
  logic [17:0] hang_addr = '0;

  ddr4_request_queue #(
    .PADDR_BITS(PADDR_BITS), .DATA_BITS(DATA_BITS), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_in(clk_in), .rst_N_in(rst_N_in),
    .req_valid_in(req_valid_in), .req_ready_out(req_ready_out), .req_write_in(req_write_in),
    .req_addr_in(req_addr_in), .req_wdata_in(req_wdata_in),
    .ctrl_valid_out(ctrl_valid_out), .ctrl_ready_in(ctrl_ready_in), .ctrl_addr_out(ctrl_addr_out),
    .ctrl_wdata_out(ctrl_wdata_out), .ctrl_wen_out(ctrl_wen_out), .ctrl_done_in(ctrl_done_in),
    .ctrl_rdata_in(ctrl_rdata_in),
    .rsp_valid_out(rsp_valid_out), .rsp_ready_in(rsp_ready_in), .rsp_write_out(rsp_write_out),
    .rsp_error_out(rsp_error_out), .rsp_rdata_out(rsp_rdata_out), .count_out(count_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [63:0] rdata_for(input logic [17:0] a);
    if (a == 18'h000A5) return 64'hDEADBEEF;
    return {a, 46'h0} ^ 64'h0123_4567_89AB_CDEF ^ {46'h0, a};
  endfunction

  // Controller and requester model: acts on falling edges, checks responses on handshake.
  initial begin : env
    logic        pending;
    logic        done_chk;
    int          cnt;
    logic [17:0] cur_addr;
    rsp_t        exp;
    pending  = 1'b0;
    done_chk = 1'b0;
    cnt      = 0;
    cur_addr = '0;
    forever begin
      @(negedge clk_in);
      if (done_chk && rst_N_in) begin
        checks++;
        if (rsp_valid_out !== 1'b1) begin
          errors++;
          $display("FAIL rsp_after_done: rsp_valid_out=%b, required 1", rsp_valid_out);
        end
      end
      done_chk      = 1'b0;
      ctrl_done_in  = 1'b0;
      ctrl_rdata_in = {$urandom, $urandom};
      if (!rst_N_in) begin
        pending = 1'b0;
      end else if (pending) begin
        if (cnt == 0) begin
          pending = 1'b0;
          if (!(hang_en && cur_addr == hang_addr)) begin
            ctrl_done_in  = 1'b1;
            ctrl_rdata_in = rdata_for(cur_addr);
            done_chk      = 1'b1;
          end
        end else begin
          cnt--;
        end
      end
      ctrl_ready_in = ctrl_accept;
      rsp_ready_in  = rsp_accept;
      if (rst_N_in && !pending && ctrl_valid_out && ctrl_ready_in) begin
        pending  = 1'b1;
        cnt      = done_delay;
        cur_addr = ctrl_addr_out[17:0];
      end
      if (rst_N_in && rsp_valid_out && rsp_ready_in) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: w=%b e=%b d=%h, required no response",
                   rsp_write_out, rsp_error_out, rsp_rdata_out);
        end else begin
          exp = sb.pop_front();
          if ({rsp_write_out, rsp_error_out, rsp_rdata_out} !== exp) begin
            errors++;
            $display("FAIL rsp_data: w=%b e=%b d=%h, required w=%b e=%b d=%h",
                     rsp_write_out, rsp_error_out, rsp_rdata_out, exp.w, exp.e, exp.d);
          end
        end
      end
    end
  end

  task automatic enqueue(input logic w, input logic [17:0] a, input logic [63:0] d);
    int   n;
    logic err;
    n = 0;
    req_valid_in = 1'b1;
    req_write_in = w;
    req_addr_in  = a;
    req_wdata_in = d;
    while (!req_ready_out && n < 500) begin
      @(negedge clk_in);
      n++;
    end
    if (!req_ready_out) begin
      checks++;
      errors++;
      $display("FAIL enqueue_timeout: req_ready_out=%b, required 1", req_ready_out);
      req_valid_in = 1'b0;
      return;
    end
    @(posedge clk_in);
    err = hang_en && (a == hang_addr);
    sb.push_back(rsp_t'{w, err, (w || err) ? 64'h0 : rdata_for(a)});
    @(negedge clk_in);
    req_valid_in = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk_in);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses outstanding, required 0", sb.size());
      sb.delete();
    end
    @(negedge clk_in);
  endtask

  task automatic test_reset();
    rst_N_in = 1'b0;
    repeat (3) @(negedge clk_in);
    checks++;
    if (count_out !== 3'd0) begin errors++; $display("FAIL reset_count: %0d, required 0", count_out); end
    checks++;
    if (req_ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready: %b, required 1", req_ready_out); end
    checks++;
    if ({ctrl_valid_out, ctrl_wen_out, ctrl_addr_out} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: valid=%b wen=%b addr=%h, required 0", ctrl_valid_out, ctrl_wen_out, ctrl_addr_out);
    end
    checks++;
    if ({rsp_valid_out, rsp_write_out, rsp_error_out, rsp_rdata_out} !== '0) begin
      errors++;
      $display("FAIL reset_rsp: valid=%b w=%b e=%b d=%h, required 0", rsp_valid_out, rsp_write_out, rsp_error_out, rsp_rdata_out);
    end
    rst_N_in = 1'b1;
    @(negedge clk_in);
  endtask

  task automatic test_single_read();
    enqueue(1'b0, 18'h000A5, 64'h0);
    checks++;
    if (ctrl_valid_out !== 1'b0) begin errors++; $display("FAIL read_latency_early: ctrl_valid_out=%b, required 0", ctrl_valid_out); end
    @(negedge clk_in);
    checks++;
    if (ctrl_valid_out !== 1'b1) begin errors++; $display("FAIL read_latency: ctrl_valid_out=%b, required 1", ctrl_valid_out); end
    checks++;
    if (ctrl_addr_out !== 19'h000A5) begin errors++; $display("FAIL read_addr: %h, required 000a5", ctrl_addr_out); end
    wait_drain(100);
  endtask

  task automatic test_single_write();
    done_delay = 5;
    enqueue(1'b1, 18'h00012, 64'h1234);
    @(negedge clk_in);
    checks++;
    if ({ctrl_valid_out, ctrl_addr_out, ctrl_wen_out, ctrl_wdata_out} !== {1'b1, 19'h40012, 1'b1, 64'h1234}) begin
      errors++;
      $display("FAIL write_issue: valid=%b addr=%h wen=%b wdata=%h, required 1 40012 1 1234",
               ctrl_valid_out, ctrl_addr_out, ctrl_wen_out, ctrl_wdata_out);
    end
    repeat (3) @(negedge clk_in);
    checks++;
    if ({ctrl_valid_out, ctrl_wen_out} !== 2'b01) begin
      errors++;
      $display("FAIL write_wait_wen: valid=%b wen=%b, required 0 1", ctrl_valid_out, ctrl_wen_out);
    end
    wait_drain(100);
    checks++;
    if (ctrl_wen_out !== 1'b0) begin errors++; $display("FAIL write_wen_clear: %b, required 0", ctrl_wen_out); end
    done_delay = 0;
  endtask

  task automatic test_fill_and_full_swap();
    ctrl_accept = 1'b0;
    for (int i = 0; i < 5; i++) enqueue(1'b0, 18'h01000 + 18'(i), 64'h0);
    checks++;
    if (count_out !== 3'd4) begin errors++; $display("FAIL full_count: %0d, required 4", count_out); end
    checks++;
    if (req_ready_out !== 1'b0) begin errors++; $display("FAIL full_ready: %b, required 0", req_ready_out); end
    ctrl_accept = 1'b1;
    enqueue(1'b1, 18'h01005, 64'hABCD);
    checks++;
    if (count_out !== 3'd4) begin errors++; $display("FAIL full_swap_count: %0d, required 4", count_out); end
    wait_drain(300);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 10; i++) begin
      done_delay = $urandom_range(0, 3);
      enqueue(1'(i), 18'h00100 + 18'(i * 7), {$urandom, $urandom});
    end
    wait_drain(400);
    checks++;
    if (count_out !== 3'd0) begin errors++; $display("FAIL wrap_count: %0d, required 0", count_out); end
    done_delay = 0;
  endtask

  task automatic test_timeout();
    int n;
    hang_en   = 1'b1;
    hang_addr = 18'h0BEEF;
    enqueue(1'b0, 18'h0BEEF, 64'h0);
    enqueue(1'b0, 18'h00777, 64'h0);
    n = 0;
    while (!ctrl_valid_out && n < 50) begin @(negedge clk_in); n++; end
    while (ctrl_valid_out && n < 100) begin @(negedge clk_in); n++; end
    n = 0;
    while (!rsp_valid_out && n < TIMEOUT + 100) begin @(negedge clk_in); n++; end
    checks++;
    if (n != TIMEOUT) begin errors++; $display("FAIL timeout_cycles: %0d, required %0d", n, TIMEOUT); end
    wait_drain(200);
    hang_en = 1'b0;
  endtask

  task automatic test_rsp_stall();
    logic [65:0] snap;
    logic        stable;
    logic        quiet;
    int          n;
    rsp_accept = 1'b0;
    enqueue(1'b0, 18'h02222, 64'h0);
    enqueue(1'b1, 18'h03333, 64'h55);
    n = 0;
    while (!rsp_valid_out && n < 100) begin @(negedge clk_in); n++; end
    snap   = {rsp_write_out, rsp_error_out, rsp_rdata_out};
    stable = rsp_valid_out;
    quiet  = 1'b1;
    repeat (20) begin
      @(negedge clk_in);
      if (!rsp_valid_out || {rsp_write_out, rsp_error_out, rsp_rdata_out} !== snap) stable = 1'b0;
      if (ctrl_valid_out) quiet = 1'b0;
    end
    checks++;
    if (stable !== 1'b1) begin errors++; $display("FAIL stall_stable: %b, required 1", stable); end
    checks++;
    if (quiet !== 1'b1) begin errors++; $display("FAIL stall_no_issue: %b, required 1", quiet); end
    rsp_accept = 1'b1;
    wait_drain(100);
  endtask

  task automatic test_reset_in_wait();
    logic seen;
    int   n;
    done_delay = 50;
    for (int i = 0; i < 3; i++) enqueue(1'b0, 18'h04000 + 18'(i), 64'h0);
    n = 0;
    while (ctrl_valid_out && n < 50) begin @(negedge clk_in); n++; end
    #2 rst_N_in = 1'b0;
    #1;
    checks++;
    if ({count_out, ctrl_valid_out, rsp_valid_out} !== 5'b0) begin
      errors++;
      $display("FAIL reset_wait: count=%0d ctrl_valid=%b rsp_valid=%b, required 0 0 0", count_out, ctrl_valid_out, rsp_valid_out);
    end
    sb.delete();
    repeat (2) @(negedge clk_in);
    rst_N_in = 1'b1;
    seen = 1'b0;
    repeat (80) begin
      @(negedge clk_in);
      if (rsp_valid_out || ctrl_valid_out) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL reset_discard: activity=%b, required 0", seen); end
    done_delay = 0;
  endtask

  initial begin
    rst_N_in      = 1'b0;
    req_valid_in  = 1'b0;
    req_write_in  = 1'b0;
    req_addr_in   = '0;
    req_wdata_in  = '0;
    ctrl_ready_in = 1'b0;
    ctrl_done_in  = 1'b0;
    ctrl_rdata_in = '0;
    rsp_ready_in  = 1'b0;
    test_reset();
    test_single_read();
    test_single_write();
    test_fill_and_full_swap();
    test_wrap();
    test_timeout();
    test_rsp_stall();
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
